// File: rtl/gsu_pkg.sv
// gsu_pkg: shared types and sizing for the GSU instruction cache fill logic.
package gsu_pkg;

  localparam int LINE_BYTES   = 16;
  localparam int LINES        = 32;
  localparam int CACHE_AW     = 9;
  localparam int CACHE_WINDOW = 512;
  localparam int LINE_AW      = 4;   // log2(LINE_BYTES), byte-within-line bits

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    HIT    = 3'd2,
    FILL   = 3'd3,
    BYP    = 3'd4
  } gsu_state_t;

endpackage

// File: rtl/gsu_cache_ram.sv
// gsu_cache_ram: 512x8 instruction cache storage, one write port and a
// registered read port. Contents are intentionally not reset.
module gsu_cache_ram
  import gsu_pkg::*;
(
  input  logic                clkin,
  input  logic                we,
  input  logic [CACHE_AW-1:0] waddr,
  input  logic [7:0]          wdata,
  input  logic [CACHE_AW-1:0] raddr,
  output logic [7:0]          rdata
);

  logic [7:0] mem [0:LINE_BYTES*LINES-1];

  // single write port plus a read port whose data appears one cycle after the address
  always_ff @(posedge clkin) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/gsu_cache_fill.sv
// gsu_cache_fill: GSU instruction-fetch initiator. Serves core byte fetches
// from the 512-byte cache, fills missing 16-byte lines over the memory bus,
// bypasses fetches outside the cache window, and owns the SNES write port and
// per-line valid flags.
// Build option: define GSU_CACHE_EARLY_ACK_EN to acknowledge a miss as soon
// as the requested byte has been written, letting the line fill finish in the
// background.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a fetch request (blocked while a bypass ack pulses)
// LOOKUP | line valid flag checked; RAM read of the target byte issued
// HIT    | RAM read data on fetch_data, fetch_ack pulses
// FILL   | 16 bus reads fill the line; aborts cleanly on cache_inval
// BYP    | single uncached bus read, ack follows the bus ack
module gsu_cache_fill
  import gsu_pkg::*;
(
  input  logic        clkin,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [7:0]  fetch_bank,
  input  logic [15:0] fetch_addr,
  output logic        fetch_ack,
  output logic [7:0]  fetch_data,
  input  logic [15:0] cbr,
  input  logic        cache_inval,
  input  logic        snes_we,
  input  logic [8:0]  snes_waddr,
  input  logic [7:0]  snes_wdata,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        busy
);

`ifdef GSU_CACHE_EARLY_ACK_EN
  localparam bit EARLY_ACK = 1'b1;
`else
  localparam bit EARLY_ACK = 1'b0;
`endif

  gsu_state_t          state_q, state_d;

  logic [15:0]         cbr_base;
  logic [15:0]         off_full;
  logic                in_win;

  logic [CACHE_AW-1:0] off_q;
  logic [7:0]          bank_q;
  logic [15:0]         base_q;
  logic [4:0]          beat_q;      // bit 4 set once all 16 beats are acked
  logic                mem_req_q;
  logic [23:0]         mem_addr_q;
  logic                ack_q;
  logic                acked_q;
  logic                abort_q;
  logic [7:0]          data_q;
  logic [LINES-1:0]    flags_q;

  logic                pend_q;
  logic [CACHE_AW-1:0] pend_addr_q;
  logic [7:0]          pend_data_q;

  logic                fill_ack;
  logic                fw_req;
  logic                fw_commit;
  logic                pend_d;
  logic                set_flag;
  logic                abort_now;
  logic [CACHE_AW-1:0] fill_caddr;
  logic [CACHE_AW-1:0] line_base;
  logic [CACHE_AW-1:0] fw_addr;
  logic [7:0]          fw_data;
  logic                ram_we;
  logic [CACHE_AW-1:0] ram_waddr;
  logic [7:0]          ram_wdata;
  logic [7:0]          ram_rdata;
  logic [15:0]         fill_addr16;
  logic [15:0]         line_addr16;

  // masking instead of slicing keeps every cbr bit in use
  assign cbr_base    = cbr & 16'hFFF0;
  assign off_full    = fetch_addr - cbr_base;
  assign in_win      = (off_full < 16'(CACHE_WINDOW));

  assign line_base   = {off_q[CACHE_AW-1:LINE_AW], {LINE_AW{1'b0}}};
  assign fill_caddr  = {off_q[CACHE_AW-1:LINE_AW], beat_q[LINE_AW-1:0]};
  assign fill_addr16 = base_q + {{(16-CACHE_AW){1'b0}}, fill_caddr};
  assign line_addr16 = base_q + {{(16-CACHE_AW){1'b0}}, line_base};
  assign abort_now   = abort_q || cache_inval;

  assign fetch_ack   = (state_q == HIT) || ack_q;
  assign fetch_data  = (state_q == HIT) ? ram_rdata : data_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign busy        = (state_q != IDLE);

  // fill writes yield to SNES writes; a displaced fill byte waits in pend_q
  always_comb begin
    fill_ack  = (state_q == FILL) && mem_req_q && mem_ack;
    fw_req    = pend_q || fill_ack;
    fw_addr   = pend_q ? pend_addr_q : fill_caddr;
    fw_data   = pend_q ? pend_data_q : mem_data;
    fw_commit = fw_req && !snes_we;
    pend_d    = fw_req && snes_we;
    ram_we    = snes_we || fw_req;
    ram_waddr = snes_we ? snes_waddr : fw_addr;
    ram_wdata = snes_we ? snes_wdata : fw_data;
  end

  // state register
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode; a completed line goes through one settle cycle so the
  // last byte is in the RAM before the registered read feeding HIT
  always_comb begin
    state_d  = state_q;
    set_flag = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_req && !ack_q) begin
          state_d = in_win ? LOOKUP : BYP;
        end
      end
      LOOKUP: begin
        state_d = (flags_q[off_q[CACHE_AW-1:LINE_AW]] && !cache_inval) ? HIT : FILL;
      end
      HIT: begin
        state_d = IDLE;
      end
      FILL: begin
        if (abort_now) begin
          if (!mem_req_q || fill_ack) begin
            state_d = IDLE;
          end
        end else if (beat_q[4] && !pend_q) begin
          set_flag = 1'b1;
          state_d  = EARLY_ACK ? IDLE : HIT;
        end
      end
      BYP: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // request capture, bus handshake, beat counting and registered acks
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      off_q      <= '0;
      bank_q     <= '0;
      base_q     <= '0;
      beat_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      ack_q      <= 1'b0;
      acked_q    <= 1'b0;
      abort_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (state_d != IDLE) begin
            off_q  <= off_full[CACHE_AW-1:0];
            bank_q <= fetch_bank;
            base_q <= cbr_base;
          end
          if (state_d == BYP) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= {fetch_bank, fetch_addr};
          end
        end
        LOOKUP: begin
          if (state_d == FILL) begin
            beat_q     <= '0;
            abort_q    <= 1'b0;
            acked_q    <= 1'b0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {bank_q, line_addr16};
          end
        end
        FILL: begin
          if (cache_inval) begin
            abort_q <= 1'b1;
          end
          if (fill_ack) begin
            mem_req_q <= 1'b0;
            beat_q    <= beat_q + 5'd1;
          end else if (state_d == FILL && !mem_req_q && !beat_q[4] && !pend_d) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= {bank_q, fill_addr16};
          end
          if (EARLY_ACK && fw_commit && (fw_addr == off_q) && !acked_q) begin
            ack_q   <= 1'b1;
            acked_q <= 1'b1;
            data_q  <= fw_data;
          end
        end
        BYP: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            data_q    <= mem_data;
            ack_q     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // holding register for a fill byte displaced by a SNES write
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (pend_d) begin
        pend_addr_q <= fw_addr;
        pend_data_q <= fw_data;
      end
    end
  end

  // per-line valid flags; invalidate wins over any set in the same cycle
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (cache_inval) begin
      flags_q <= '0;
    end else begin
      if (set_flag) begin
        flags_q[off_q[CACHE_AW-1:LINE_AW]] <= 1'b1;
      end
      if (snes_we && (snes_waddr[LINE_AW-1:0] == {LINE_AW{1'b1}})) begin
        flags_q[snes_waddr[CACHE_AW-1:LINE_AW]] <= 1'b1;
      end
    end
  end

  gsu_cache_ram u_ram (
    .clkin (clkin),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (off_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_gsu_cache_fill.sv
// tb_gsu_cache_fill: directed bench for gsu_cache_fill with a bus responder
// that acks each read two cycles after the request. Bus byte at address a is
// a[7:0] ^ a[15:8] ^ 8'h5A; expected bytes below are worked out by hand.
module tb_gsu_cache_fill;

`ifdef GSU_CACHE_EARLY_ACK_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clkin;
  logic        rst_n;
  logic        fetch_req;
  logic [7:0]  fetch_bank;
  logic [15:0] fetch_addr;
  logic        fetch_ack;
  logic [7:0]  fetch_data;
  logic [15:0] cbr;
  logic        cache_inval;
  logic        inval_tb;
  logic        inval_rsp;
  logic        snes_we;
  logic [8:0]  snes_waddr;
  logic [7:0]  snes_wdata;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic        busy;

  assign cache_inval = inval_tb | inval_rsp;

  gsu_cache_fill dut (
    .clkin       (clkin),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_bank  (fetch_bank),
    .fetch_addr  (fetch_addr),
    .fetch_ack   (fetch_ack),
    .fetch_data  (fetch_data),
    .cbr         (cbr),
    .cache_inval (cache_inval),
    .snes_we     (snes_we),
    .snes_waddr  (snes_waddr),
    .snes_wdata  (snes_wdata),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .busy        (busy)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] bus_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // bus responder: ack two cycles after a request, optionally injecting an
  // invalidate on first sight of read number inval_at, or a SNES write to
  // 0x01F alongside the ack of read number snes_at
  int          rd_cnt   = 0;
  int          inval_at = -1;
  int          snes_at  = -1;
  logic [23:0] rd_addr [0:255];

  initial begin
    int age;
    age = 0;
    mem_ack = 1'b0; mem_data = 8'h00;
    snes_we = 1'b0; snes_waddr = 9'h000; snes_wdata = 8'h00;
    inval_rsp = 1'b0;
    forever begin
      @(negedge clkin);
      snes_we   = 1'b0;
      inval_rsp = 1'b0;
      if (mem_ack) begin
        mem_ack = 1'b0;
        age = 0;
      end else if (mem_req) begin
        if (age == 0 && rd_cnt == inval_at) inval_rsp = 1'b1;
        if (age >= 1) begin
          mem_ack  = 1'b1;
          mem_data = bus_byte(mem_addr);
          if (rd_cnt == snes_at) begin
            snes_we = 1'b1; snes_waddr = 9'h01F; snes_wdata = 8'hC3;
          end
          if (rd_cnt < 256) rd_addr[rd_cnt] = mem_addr;
          rd_cnt++;
          age = 0;
        end else begin
          age++;
        end
      end else begin
        age = 0;
      end
    end
  end

  task automatic run_fetch(input logic [7:0] bank, input logic [15:0] pc,
                           output int lat, output logic [7:0] data,
                           output int reads_at_ack, output logic ok);
    int base;
    base = rd_cnt;
    @(negedge clkin);
    fetch_bank = bank; fetch_addr = pc; fetch_req = 1'b1;
    ok = 1'b0; lat = 0; data = 8'h00; reads_at_ack = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clkin);
      lat++;
      if (fetch_ack) begin
        ok = 1'b1; data = fetch_data; reads_at_ack = rd_cnt - base;
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clkin);
      if (!busy) done = 1'b1;
    end
    check_eq(tag, done, 1);
  endtask

  task automatic pulse_inval();
    @(negedge clkin); inval_tb = 1'b1;
    @(negedge clkin); inval_tb = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat, racks, rd0;
    logic [7:0] d;
    logic       ok;

    rst_n = 1'b0; fetch_req = 1'b0; fetch_bank = 8'h00; fetch_addr = 16'h0000;
    cbr = 16'h0000; inval_tb = 1'b0;
    repeat (3) @(negedge clkin);
    check_eq("rst_fetch_ack",  fetch_ack,  0);
    check_eq("rst_fetch_data", fetch_data, 0);
    check_eq("rst_mem_req",    mem_req,    0);
    check_eq("rst_mem_addr",   mem_addr,   0);
    check_eq("rst_busy",       busy,       0);
    rst_n = 1'b1;
    @(negedge clkin);

    // miss at PC 5, window base 0: whole line 0 fetched
    rd0 = rd_cnt;
    run_fetch(8'h00, 16'h0005, lat, d, racks, ok);
    check_eq("miss_ack", ok, 1);
    check_eq("miss_data", d, 8'h5F);
    wait_idle("miss_idle");
    check_eq("miss_reads", rd_cnt - rd0, 16);
    for (int k = 0; k < 16; k++) check_eq($sformatf("miss_addr%0d", k), rd_addr[rd0 + k], k);

    // same PC hits: no bus traffic, ack two cycles after the request
    rd0 = rd_cnt;
    run_fetch(8'h00, 16'h0005, lat, d, racks, ok);
    check_eq("hit_ack", ok, 1);
    check_eq("hit_lat", lat, 2);
    check_eq("hit_data", d, 8'h5F);
    check_eq("hit_reads", rd_cnt - rd0, 0);

    // outside the window: one uncached read at {PBR,PC}
    cbr = 16'h8000;
    rd0 = rd_cnt;
    run_fetch(8'h12, 16'h7FFF, lat, d, racks, ok);
    check_eq("byp_ack", ok, 1);
    check_eq("byp_lat", lat, 3);
    check_eq("byp_data", d, 8'hDA);
    wait_idle("byp_idle");
    check_eq("byp_reads", rd_cnt - rd0, 1);
    check_eq("byp_addr", rd_addr[rd0], 24'h127FFF);

    // base 0xFFF0, PC 3: offset 0x13, line 1, bus addresses wrap to 0x0000
    cbr = 16'hFFF0;
    rd0 = rd_cnt;
    run_fetch(8'h00, 16'h0003, lat, d, racks, ok);
    check_eq("wrap_ack", ok, 1);
    check_eq("wrap_data", d, 8'h59);
    wait_idle("wrap_idle");
    check_eq("wrap_reads", rd_cnt - rd0, 16);
    check_eq("wrap_addr0", rd_addr[rd0], 24'h000000);
    check_eq("wrap_addr3", rd_addr[rd0 + 3], 24'h000003);
    check_eq("wrap_addr15", rd_addr[rd0 + 15], 24'h00000F);
    rd0 = rd_cnt;
    run_fetch(8'h00, 16'h0003, lat, d, racks, ok);
    check_eq("wrap_hit_lat", lat, 2);
    check_eq("wrap_hit_data", d, 8'h59);
    check_eq("wrap_hit_reads", rd_cnt - rd0, 0);

    // invalidate while beat 7 is outstanding: abort, then refill all 16 beats
    cbr = 16'h0000;
    rd0 = rd_cnt;
    inval_at = rd0 + 7;
    run_fetch(8'h00, 16'h002A, lat, d, racks, ok);
    inval_at = -1;
    check_eq("inval_ack", ok, 1);
    check_eq("inval_data", d, 8'h70);
    check_eq("inval_reads_at_ack", racks, EARLY ? 19 : 24);
    wait_idle("inval_idle");
    check_eq("inval_reads", rd_cnt - rd0, 24);
    check_eq("inval_addr7", rd_addr[rd0 + 7], 24'h000027);
    check_eq("inval_addr8", rd_addr[rd0 + 8], 24'h000020);
    check_eq("inval_addr23", rd_addr[rd0 + 23], 24'h00002F);

    // SNES write to 0x01F colliding with the fill write of beat 5
    pulse_inval();
    rd0 = rd_cnt;
    snes_at = rd0 + 5;
    run_fetch(8'h00, 16'h0005, lat, d, racks, ok);
    snes_at = -1;
    check_eq("snes_fill_ack", ok, 1);
    check_eq("snes_fill_data", d, 8'h5F);
    wait_idle("snes_idle");
    check_eq("snes_fill_reads", rd_cnt - rd0, 16);
    rd0 = rd_cnt;
    run_fetch(8'h00, 16'h001F, lat, d, racks, ok);
    check_eq("snes_hit_lat", lat, 2);
    check_eq("snes_hit_data", d, 8'hC3);
    check_eq("snes_hit_reads", rd_cnt - rd0, 0);

    // PC 2 after invalidate: early-ack builds answer after beat 2
    pulse_inval();
    rd0 = rd_cnt;
    run_fetch(8'h00, 16'h0002, lat, d, racks, ok);
    check_eq("pc2_ack", ok, 1);
    check_eq("pc2_data", d, 8'h58);
    check_eq("pc2_reads_at_ack", racks, EARLY ? 3 : 16);
    wait_idle("pc2_idle");
    check_eq("pc2_reads", rd_cnt - rd0, 16);

    // asynchronous reset in the middle of a bypass read
    @(negedge clkin);
    cbr = 16'h8000; fetch_bank = 8'h12; fetch_addr = 16'h7FFF; fetch_req = 1'b1;
    @(negedge clkin);
    check_eq("arst_req_before", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_req_dropped", mem_req, 0);
    check_eq("arst_busy", busy, 0);
    fetch_req = 1'b0;
    @(negedge clkin);
    rst_n = 1'b1;
    repeat (2) @(negedge clkin);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
